dbg_shift_display: RTL and testbench
====================================

# dbg_shift_display

Serial shift-register driver that pushes a debug word (the CPU's r0 debug value) out to an external 74HC595-style LED chain over a three-wire clock/data/latch link. It sits directly downstream of the FPGA top level and consumes the debug bus the core exports. It resends automatically when the value changes, on a periodic refresh, and on an explicit load strobe. All logic runs in the divided system clock domain.

## Interface
Parameters:
- DATA_W, 16, width of the displayed word and number of bits per frame (>=2)
- CLK_DIV, 4, duration in d_clk cycles of each serial-clock half-period and of the latch pulse (>=1)
- REFRESH, 65536, d_clk cycles between forced resends when idle (>=2)

Ports:
- d_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-low
- i_data  in  DATA_W  word to display; sampled only at frame start
- i_load  in  1  single-cycle request to send a frame regardless of change
- o_sclk  out  1  serial shift clock; data is valid on its rising edge
- o_sdata  out  1  serial data, MSB first
- o_latch  out  1  storage-register latch pulse
- o_busy  out  1  high while a frame is in progress

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- Reset (i_rst=0 at an edge) values:
  - o_sclk=0, o_sdata=0, o_latch=0, o_busy=0
  - state IDLE; shadow and last_sent cleared; refresh counter=0
  - pending=1, so the first frame after reset is always sent.
- Start condition in IDLE: pending | i_load | (i_data != last_sent) | (refresh counter == REFRESH-1).
- On start, in the same edge:
  - shadow and last_sent <= i_data; bit index <= DATA_W-1
  - pending <= 0; refresh counter <= 0
  - o_sdata <= i_data[DATA_W-1]; o_busy <= 1; state <= SHIFT_LO.
- SHIFT_LO: o_sclk=0 for CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI: o_sclk=1 for CLK_DIV cycles, then:
  - if bit index > 0: decrement the index, present the next shadow bit on o_sdata, go to SHIFT_LO;
  - else: o_sclk=0, o_latch=1, go to LATCH.
- LATCH: o_latch=1 for CLK_DIV cycles, then o_latch=0, o_busy=0, o_sdata=0, state IDLE.
- Changes on i_data during a frame are ignored. The comparison against last_sent after returning to IDLE catches them.
- i_load while busy sets pending. The request is served at the first IDLE cycle and is never dropped.
- The refresh counter increments only in IDLE and is cleared at every frame start.
- Reset mid-frame aborts immediately to reset values. No partial latch pulse is emitted.

## Timing
- Start decision is registered: outputs change on the edge that samples the start condition.
- o_busy is high for exactly 2·CLK_DIV·DATA_W + CLK_DIV cycles.
- The minimum gap between back-to-back frames is 1 IDLE cycle.
- o_sdata changes only while o_sclk=0, at least CLK_DIV cycles before each rising edge of o_sclk, and holds CLK_DIV cycles after it.
- o_latch rises on the same edge that drops the final o_sclk high phase. It is never high while o_sclk=1.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `dbg_shift_pkg` holds:
  - the state enum (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3)
  - the default DATA_W, CLK_DIV and REFRESH constants.
- One sub-module, `phase_timer`: a down-counter of width clog2(CLK_DIV) with load and a terminal-count output. The FSM uses it for every phase duration.
- The bit index counter and refresh counter stay in the top module.

## Test plan
Bench parameters: DATA_W=8, CLK_DIV=2, REFRESH=64.
- Reset release with i_data=0x00:
  - frame starts on the first post-reset edge;
  - o_busy high for 34 cycles; 8 sclk rises sample 0; one latch pulse 2 cycles wide.
- Set i_data=0xA5 while idle:
  - frame starts next edge; sampled bits 1,0,1,0,0,1,0,1; latch rises on the edge where the 8th sclk high ends.
- Change i_data 0xA5→0x3C at cycle 10 of a 0xA5 frame:
  - frame shifts 0xA5 unchanged;
  - a 0x3C frame starts 1 cycle after o_busy falls.
- Pulse i_load during a frame with i_data constant:
  - exactly one extra frame with the same value follows after the 1-cycle gap.
- Hold i_data constant and idle:
  - resend occurs every 64 idle cycles + 34 busy cycles;
  - no resend if REFRESH is not reached.
- Assert i_rst=0 during SHIFT_HI of bit 3:
  - next edge shows o_sclk=0, o_latch=0, o_busy=0;
  - after release, a full frame is sent (pending=1).

Source files
------------

// File: rtl/dbg_shift_display_pkg.sv
// Purpose: shared state encoding, default sizing and counter-width helper for the debug shift display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbg_shift_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_REFRESH = 65536;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dbg_shift_display_if.sv
// Purpose: debug word in / three-wire LED chain out bundle for dbg_shift_display.
// Latency: n/a (wires only).
// Backpressure: none; o_busy is status only, i_load while busy is queued by the driver.
interface dbg_shift_display_if #(
  parameter int DATA_W = dbg_shift_pkg::DEF_DATA_W
) ();

  logic [DATA_W-1:0] i_data;
  logic              i_load;
  logic              o_sclk;
  logic              o_sdata;
  logic              o_latch;
  logic              o_busy;

  // Source of the debug word (core side).
  modport master (
    output i_data, i_load,
    input  o_sclk, o_sdata, o_latch, o_busy
  );

  // The shift-register driver itself.
  modport slave (
    input  i_data, i_load,
    output o_sclk, o_sdata, o_latch, o_busy
  );

endinterface

// File: rtl/dbg_shift_display_phase_timer.sv
// Purpose: down-counter timing each serial phase; tc flags the last cycle of the phase.
// Latency: load -> tc after CLK_DIV-1 further cycles (phase lasts CLK_DIV cycles).
// Backpressure: none; free-running decrement until zero, reload on demand.
module phase_timer
  import dbg_shift_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic d_clk,
  input  logic i_rst,
  input  logic load,
  output logic tc
);

  localparam int         W        = cnt_w(CLK_DIV);
  localparam logic [W-1:0] LOAD_VAL = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  // Reload at phase entry, otherwise count down and park at zero.
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/dbg_shift_display.sv
// Purpose: shifts the debug word MSB-first into a 74HC595-style chain, then pulses latch.
// Latency: frame starts on the edge sampling the start condition; busy for 2*CLK_DIV*DATA_W+CLK_DIV cycles.
// Backpressure: none; i_data is sampled only at frame start, i_load while busy is held as pending.
module dbg_shift_display
  import dbg_shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int REFRESH = DEF_REFRESH
) (
  input  logic              d_clk,
  input  logic              i_rst,
  dbg_shift_display_if.slave bus
);

  localparam int IDX_W = cnt_w(DATA_W);
  localparam int REF_W = cnt_w(REFRESH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] last_sent;
  logic [IDX_W-1:0]  bit_idx;
  logic [REF_W-1:0]  refresh_cnt;
  logic              pending;

  logic start;
  logic tc;
  logic timer_load;
  logic idx_dec;
  logic sclk_nxt, sdata_nxt, latch_nxt, busy_nxt;

  phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .d_clk (d_clk),
    .i_rst (i_rst),
    .load  (timer_load),
    .tc    (tc)
  );

  // A frame goes out after reset, on request, on a new value, or when the refresh interval expires.
  assign start = (state == IDLE) &&
                 (pending || bus.i_load || (bus.i_data != last_sent) ||
                  (refresh_cnt == REF_W'(REFRESH - 1)));

  // Next state and next registered output values; outputs hold unless a phase ends.
  always_comb begin
    state_nxt  = state;
    sclk_nxt   = bus.o_sclk;
    sdata_nxt  = bus.o_sdata;
    latch_nxt  = bus.o_latch;
    busy_nxt   = bus.o_busy;
    timer_load = 1'b0;
    idx_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SHIFT_LO;
          sdata_nxt  = bus.i_data[DATA_W-1];
          busy_nxt   = 1'b1;
          timer_load = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (tc) begin
          state_nxt  = SHIFT_HI;
          sclk_nxt   = 1'b1;
          timer_load = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (tc) begin
          sclk_nxt   = 1'b0;
          timer_load = 1'b1;
          if (bit_idx != '0) begin
            idx_dec   = 1'b1;
            sdata_nxt = shadow[bit_idx - 1'b1];
            state_nxt = SHIFT_LO;
          end else begin
            latch_nxt = 1'b1;
            state_nxt = LATCH;
          end
        end
      end
      LATCH: begin
        if (tc) begin
          state_nxt = IDLE;
          latch_nxt = 1'b0;
          busy_nxt  = 1'b0;
          sdata_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, outputs, frame bookkeeping; reset drops everything at once so no partial latch escapes.
  always_ff @(posedge d_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      bus.o_sclk  <= 1'b0;
      bus.o_sdata <= 1'b0;
      bus.o_latch <= 1'b0;
      bus.o_busy  <= 1'b0;
      shadow      <= '0;
      last_sent   <= '0;
      bit_idx     <= '0;
      refresh_cnt <= '0;
      pending     <= 1'b1;
    end else begin
      state       <= state_nxt;
      bus.o_sclk  <= sclk_nxt;
      bus.o_sdata <= sdata_nxt;
      bus.o_latch <= latch_nxt;
      bus.o_busy  <= busy_nxt;
      if (start) begin
        shadow      <= bus.i_data;
        last_sent   <= bus.i_data;
        bit_idx     <= IDX_W'(DATA_W - 1);
        pending     <= 1'b0;
        refresh_cnt <= '0;
      end else begin
        if (state == IDLE) begin
          refresh_cnt <= refresh_cnt + 1'b1;
        end else if (bus.i_load) begin
          pending <= 1'b1;
        end
        if (idx_dec) begin
          bit_idx <= bit_idx - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_shift_display.sv
module tb_dbg_shift_display;

  localparam int DW       = 8;
  localparam int CD       = 2;
  localparam int RF       = 64;
  localparam int BUSY_LEN = 2 * CD * DW + CD;

  logic d_clk = 1'b0;
  logic i_rst = 1'b0;

  dbg_shift_display_if #(.DATA_W(DW)) bus ();

  dbg_shift_display #(
    .DATA_W  (DW),
    .CLK_DIV (CD),
    .REFRESH (RF)
  ) dut (
    .d_clk (d_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 d_clk = ~d_clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [DW-1:0] exp_q[$];
  bit            ignore_frame = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic          load;
    logic          exp_start;
  } vec_t;

  vec_t tab[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
  endtask

  task automatic wait_busy(input logic v, input int budget, input string nm);
    int n = 0;
    while (bus.o_busy !== v && n < budget) begin
      @(negedge d_clk);
      n++;
    end
    check(nm, 32'(bus.o_busy), 32'(v));
  endtask

  // Frame monitor: reassembles each frame from sclk rises and scores it against the queue.
  initial begin
    logic          pbusy, psclk, platch, psdata, held;
    logic [DW-1:0] word;
    int nbits, busy_len, latch_len, timing_err, stable;
    logic latch_edge;
    pbusy = 1'b0; psclk = 1'b0; platch = 1'b0; psdata = 1'b0; held = 1'b0;
    word = '0; nbits = 0; busy_len = 0; latch_len = 0; timing_err = 0; stable = 0;
    latch_edge = 1'b0;
    forever begin
      @(negedge d_clk);
      if (bus.o_busy === 1'b1 && pbusy === 1'b0) begin
        word = '0; nbits = 0; busy_len = 0; latch_len = 0; timing_err = 0; latch_edge = 1'b0;
      end
      if (bus.o_sdata === psdata) stable++;
      else stable = 0;
      if (bus.o_busy === 1'b1) busy_len++;
      if (bus.o_sclk === 1'b1 && psclk === 1'b0) begin
        word  = {word[DW-2:0], bus.o_sdata};
        nbits++;
        held  = bus.o_sdata;
        if (stable < CD) timing_err++;
      end else if (bus.o_sclk === 1'b1 && bus.o_sdata !== held) begin
        timing_err++;
      end
      if (bus.o_latch === 1'b1) begin
        latch_len++;
        if (bus.o_sclk !== 1'b0) timing_err++;
      end
      if (bus.o_latch === 1'b1 && platch === 1'b0)
        latch_edge = (psclk === 1'b1) && (bus.o_sclk === 1'b0) && (nbits == DW);
      if (bus.o_busy === 1'b0 && pbusy === 1'b1) begin
        if (ignore_frame) begin
          ignore_frame = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          check("busy_len", 32'(busy_len), 32'(BUSY_LEN));
          check("sclk_rises", 32'(nbits), 32'(DW));
          check("latch_len", 32'(latch_len), 32'(CD));
          check("latch_edge", 32'(latch_edge), 32'd1);
          check("sdata_timing_errs", 32'(timing_err), 32'd0);
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL frame_word: got 0x%0h, no frame expected", word);
          end else begin
            check("frame_word", 32'(word), 32'(exp_q.pop_front()));
          end
        end
      end
      pbusy  = bus.o_busy;
      psclk  = bus.o_sclk;
      platch = bus.o_latch;
      psdata = bus.o_sdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  initial begin
    int idle;
    int rises;
    logic ps;

    tab[0] = '{8'hA5, 1'b0, 1'b1};
    tab[1] = '{8'hA5, 1'b0, 1'b0};
    tab[2] = '{8'h3C, 1'b0, 1'b1};
    tab[3] = '{8'h3C, 1'b1, 1'b1};
    tab[4] = '{8'hFF, 1'b0, 1'b1};
    tab[5] = '{8'h01, 1'b0, 1'b1};
    tab[6] = '{8'h80, 1'b1, 1'b1};
    tab[7] = '{8'h80, 1'b0, 1'b0};
    tab[8] = '{8'h7E, 1'b0, 1'b1};

    bus.i_data = '0;
    bus.i_load = 1'b0;
    i_rst      = 1'b0;

    // Reset values, then the first frame goes out unconditionally.
    repeat (3) @(negedge d_clk);
    check("rst_sclk",  32'(bus.o_sclk),  32'd0);
    check("rst_sdata", 32'(bus.o_sdata), 32'd0);
    check("rst_latch", 32'(bus.o_latch), 32'd0);
    check("rst_busy",  32'(bus.o_busy),  32'd0);
    exp_q.push_back(8'h00);
    i_rst = 1'b1;
    @(negedge d_clk);
    check("first_start", 32'(bus.o_busy), 32'd1);
    wait_busy(1'b0, 60, "first_done");
    repeat (3) @(negedge d_clk);
    check("idle_no_resend", 32'(bus.o_busy), 32'd0);

    // Idle-time stimulus table.
    for (int i = 0; i < 9; i++) begin
      bus.i_data = tab[i].data;
      bus.i_load = tab[i].load;
      if (tab[i].exp_start) exp_q.push_back(tab[i].data);
      @(negedge d_clk);
      bus.i_load = 1'b0;
      check($sformatf("vec%0d_start", i), 32'(bus.o_busy), 32'(tab[i].exp_start));
      if (tab[i].exp_start) wait_busy(1'b0, 60, $sformatf("vec%0d_done", i));
      repeat (2) @(negedge d_clk);
    end

    // New value mid-frame is ignored, then sent after a one-cycle gap.
    bus.i_data = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge d_clk);
    check("mid_start", 32'(bus.o_busy), 32'd1);
    repeat (9) @(negedge d_clk);
    bus.i_data = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_busy(1'b0, 60, "mid_first_done");
    @(negedge d_clk);
    check("mid_restart", 32'(bus.o_busy), 32'd1);
    wait_busy(1'b0, 60, "mid_second_done");

    // Load during a frame queues exactly one repeat.
    bus.i_data = 8'h66;
    exp_q.push_back(8'h66);
    @(negedge d_clk);
    check("load_frame_start", 32'(bus.o_busy), 32'd1);
    repeat (5) @(negedge d_clk);
    bus.i_load = 1'b1;
    exp_q.push_back(8'h66);
    @(negedge d_clk);
    bus.i_load = 1'b0;
    wait_busy(1'b0, 60, "load_first_done");
    @(negedge d_clk);
    check("load_restart", 32'(bus.o_busy), 32'd1);
    wait_busy(1'b0, 60, "load_second_done");
    repeat (10) @(negedge d_clk);
    check("load_single_extra", 32'(bus.o_busy), 32'd0);
    check("queue_after_load", 32'(exp_q.size()), 32'd0);

    // Periodic refresh with a constant value.
    exp_q.push_back(8'h66);
    wait_busy(1'b1, 120, "refresh1_start");
    wait_busy(1'b0, 60, "refresh1_done");
    exp_q.push_back(8'h66);
    idle = 1;
    while (bus.o_busy !== 1'b1 && idle < 200) begin
      @(negedge d_clk);
      if (bus.o_busy === 1'b0) idle++;
    end
    check("refresh_idle_cycles", 32'(idle), 32'(RF));
    wait_busy(1'b0, 60, "refresh2_done");

    // Reset while shifting bit index 3 (fifth bit) aborts cleanly.
    bus.i_data = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge d_clk);
    check("abort_frame_start", 32'(bus.o_busy), 32'd1);
    rises = 0;
    ps    = bus.o_sclk;
    for (int n = 0; n < 100 && rises < 5; n++) begin
      @(negedge d_clk);
      if (bus.o_sclk === 1'b1 && ps === 1'b0) rises++;
      ps = bus.o_sclk;
    end
    check("abort_reached_bit3", 32'(rises), 32'd5);
    ignore_frame = 1'b1;
    i_rst        = 1'b0;
    bus.i_data   = 8'h00;
    @(negedge d_clk);
    check("abort_sclk",  32'(bus.o_sclk),  32'd0);
    check("abort_latch", 32'(bus.o_latch), 32'd0);
    check("abort_busy",  32'(bus.o_busy),  32'd0);
    check("abort_sdata", 32'(bus.o_sdata), 32'd0);
    @(negedge d_clk);
    exp_q.push_back(8'h00);
    i_rst = 1'b1;
    @(negedge d_clk);
    check("post_reset_start", 32'(bus.o_busy), 32'd1);
    wait_busy(1'b0, 60, "post_reset_done");
    repeat (5) @(negedge d_clk);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
